fetch_ctrl: RTL and testbench

Sequencing controller for the Fetch stage and its dynamic branch predictor (BTB/BHT). After reset it runs a clear sweep over all 16 predictor entries while holding the PC. In normal operation it resolves the branch sitting in IF/ID and generates the predictor write enables, PC redirect and IF/ID flush. It also handles HLT and global stalls, and keeps branch and misprediction statistics. It sits between the Decode stage outputs and the Fetch/DBP inputs.

---
 rtl/fetch_ctrl.sv | 117 +++++++++++
 tb/tb_fetch_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: predictor clear sweep after reset, branch
// resolution in IF/ID (predictor training, PC redirect, squash), HLT,
// global stalls and branch/misprediction statistics.
module fetch_ctrl #(
  parameter  int NUM_ENTRIES = 16,
  parameter  int CNT_W       = 16,
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid,
  input  logic             is_branch,
  input  logic             hlt,
  input  logic             hazard_stall,
  input  logic             actual_taken,
  input  logic [15:0]      actual_target,
  input  logic [15:0]      IF_ID_PC_curr,
  input  logic [1:0]       IF_ID_prediction,
  input  logic [15:0]      IF_ID_predicted_target,
  output logic             pc_en,
  output logic             wen_BTB,
  output logic             wen_BHT,
  output logic [IDX_W-1:0] upd_idx,
  output logic             upd_taken,
  output logic [15:0]      upd_target,
  output logic             update_PC,
  output logic [15:0]      redirect_target,
  output logic             IF_ID_flush,
  output logic             init_busy,
  output logic             halted,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_REDIR, S_HALT} state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx;
  logic             res, br, mispred, tmiss, br_cnt;

  // Resolution qualifiers; hlt overrides is_branch so a HLT never trains.
  assign res     = dec_valid & ~hazard_stall;
  assign br      = res & is_branch & ~hlt;
  assign mispred = IF_ID_prediction[1] != actual_taken;
  assign tmiss   = actual_taken & (IF_ID_predicted_target != actual_target);

  // State, sweep index and saturating statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_INIT;
      idx              <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      state <= state_nx;
      if (state == S_INIT) idx <= idx + IDX_W'(1);
      if (br_cnt && branch_count != '1)
        branch_count <= branch_count + CNT_W'(1);
      if (update_PC && mispredict_count != '1)
        mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

  // Next state and all combinational outputs; idle values are zero
  always_comb begin
    state_nx        = state;
    pc_en           = 1'b0;
    wen_BTB         = 1'b0;
    wen_BHT         = 1'b0;
    upd_idx         = '0;
    upd_taken       = 1'b0;
    upd_target      = '0;
    update_PC       = 1'b0;
    redirect_target = '0;
    IF_ID_flush     = 1'b0;
    init_busy       = 1'b0;
    halted          = 1'b0;
    br_cnt          = 1'b0;
    case (state)
      S_INIT: begin
        init_busy = 1'b1;
        wen_BTB   = 1'b1;
        wen_BHT   = 1'b1;
        upd_idx   = idx;
        if (idx == IDX_W'(NUM_ENTRIES - 1)) state_nx = S_RUN;
      end
      S_RUN: begin
        br_cnt     = br;
        wen_BHT    = br;
        wen_BTB    = br & (actual_taken | tmiss);
        upd_idx    = IF_ID_PC_curr[IDX_W:1];
        upd_taken  = actual_taken;
        upd_target = actual_target;
        update_PC  = br & (mispred | tmiss);
        pc_en      = ~hazard_stall;
        if (update_PC) begin
          redirect_target = actual_taken ? actual_target : IF_ID_PC_curr + 16'd2;
          IF_ID_flush     = 1'b1;
          pc_en           = 1'b1;
          state_nx        = S_REDIR;
        end else if (res & hlt) begin
          state_nx = S_HALT;
        end
      end
      S_REDIR: begin
        // IF/ID holds the squashed wrong-path instruction: ignore decode
        pc_en = ~hazard_stall;
        if (!hazard_stall) state_nx = S_RUN;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_nx = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic, all
// compared against a behavioural model of the controller's rules.
module tb_fetch_ctrl;
  localparam int CNT_W = 5;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             dec_valid = 0, is_branch = 0, hlt = 0, hazard_stall = 0, actual_taken = 0;
  logic [15:0]      actual_target = 0, IF_ID_PC_curr = 0, IF_ID_predicted_target = 0;
  logic [1:0]       IF_ID_prediction = 0;
  logic             pc_en, wen_BTB, wen_BHT, upd_taken, update_PC, IF_ID_flush, init_busy, halted;
  logic [3:0]       upd_idx;
  logic [15:0]      upd_target, redirect_target;
  logic [CNT_W-1:0] branch_count, mispredict_count;

  fetch_ctrl #(.NUM_ENTRIES(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .is_branch(is_branch), .hlt(hlt),
    .hazard_stall(hazard_stall), .actual_taken(actual_taken), .actual_target(actual_target),
    .IF_ID_PC_curr(IF_ID_PC_curr), .IF_ID_prediction(IF_ID_prediction),
    .IF_ID_predicted_target(IF_ID_predicted_target), .pc_en(pc_en), .wen_BTB(wen_BTB),
    .wen_BHT(wen_BHT), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_target(upd_target),
    .update_PC(update_PC), .redirect_target(redirect_target), .IF_ID_flush(IF_ID_flush),
    .init_busy(init_busy), .halted(halted), .branch_count(branch_count),
    .mispredict_count(mispredict_count));

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  // Model: remaining sweep entries, squash pending, halted, counters
  int m_init_left, m_idx, m_bc, m_mc, halt_cycles;
  bit m_sq, m_halt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_init_left = 16; m_idx = 0; m_sq = 0; m_halt = 0; m_bc = 0; m_mc = 0;
  endtask

  task automatic set_in(input bit dv, input bit isb, input bit h, input bit st, input bit tk,
                        input logic [15:0] tgt, input logic [15:0] pc,
                        input logic [1:0] pred, input logic [15:0] ptgt);
    dec_valid = dv; is_branch = isb; hlt = h; hazard_stall = st; actual_taken = tk;
    actual_target = tgt; IF_ID_PC_curr = pc; IF_ID_prediction = pred;
    IF_ID_predicted_target = ptgt;
  endtask

  // Assert reset asynchronously mid-cycle, check, release after an edge
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_init_busy", init_busy, 1);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_halted", halted, 0);
    chk("rst_update_PC", update_PC, 0);
    chk("rst_flush", IF_ID_flush, 0);
    chk("rst_upd_idx", upd_idx, 0);
    chk("rst_bcount", branch_count, 0);
    chk("rst_mcount", mispredict_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One cycle: compare every output with the model, then advance both
  task automatic step();
    bit e_pc, e_wb, e_wh, e_up, e_ib, e_ha, e_tk, res, br, mis, tm;
    int e_idx, e_tg, e_rt;
    e_pc = 0; e_wb = 0; e_wh = 0; e_up = 0; e_ib = 0; e_ha = 0; e_tk = 0;
    e_idx = 0; e_tg = 0; e_rt = 0; br = 0;
    @(negedge clk);
    res = dec_valid && !hazard_stall;
    if (m_init_left > 0) begin
      e_ib = 1; e_wb = 1; e_wh = 1; e_idx = m_idx;
    end else if (m_halt) begin
      e_ha = 1;
    end else if (m_sq) begin
      e_pc = !hazard_stall;
    end else begin
      br  = res && is_branch && !hlt;
      mis = IF_ID_prediction[1] != actual_taken;
      tm  = actual_taken && (IF_ID_predicted_target != actual_target);
      e_wh = br; e_wb = br && (actual_taken || tm); e_up = br && (mis || tm);
      e_pc = e_up ? 1 : !hazard_stall;
      e_idx = (IF_ID_PC_curr / 2) % 16; e_tk = actual_taken; e_tg = actual_target;
      e_rt = actual_taken ? actual_target : (IF_ID_PC_curr + 2) % 65536;
    end
    chk("pc_en", pc_en, e_pc);
    chk("wen_BHT", wen_BHT, e_wh);
    chk("wen_BTB", wen_BTB, e_wb);
    chk("update_PC", update_PC, e_up);
    chk("IF_ID_flush", IF_ID_flush, e_up);
    chk("init_busy", init_busy, e_ib);
    chk("halted", halted, e_ha);
    chk("branch_count", branch_count, m_bc);
    chk("mispredict_count", mispredict_count, m_mc);
    if (e_wh || e_wb) begin
      chk("upd_idx", upd_idx, e_idx);
      chk("upd_taken", upd_taken, e_tk);
      chk("upd_target", upd_target, e_tg);
    end
    if (e_up) chk("redirect_target", redirect_target, e_rt);
    @(posedge clk);
    if (m_init_left > 0) begin
      m_init_left--; m_idx++;
    end else if (m_halt) begin
    end else if (m_sq) begin
      if (!hazard_stall) m_sq = 0;
    end else begin
      if (br && m_bc < CMAX) m_bc++;
      if (e_up) begin
        m_sq = 1;
        if (m_mc < CMAX) m_mc++;
      end else if (res && hlt) m_halt = 1;
    end
    #1;
  endtask

  initial begin
    model_reset();
    #12;
    do_reset();
    // Init sweep: 16 writing cycles, then running
    repeat (16) step();
    #1;
    chk("sweep_pc_en", pc_en, 1);
    chk("sweep_busy", init_busy, 0);

    // Taken mispredict
    set_in(1, 1, 0, 0, 1, 16'h0040, 16'h000A, 2'b01, 16'h0000); #1;
    chk("tm_idx", upd_idx, 5);
    chk("tm_wen_BHT", wen_BHT, 1);
    chk("tm_wen_BTB", wen_BTB, 1);
    chk("tm_update_PC", update_PC, 1);
    chk("tm_redirect", redirect_target, 16'h0040);
    chk("tm_flush", IF_ID_flush, 1);
    step();
    set_in(1, 1, 0, 0, 1, 16'h0080, 16'h000C, 2'b00, 16'h0000); #1;
    chk("squash_no_redirect", update_PC, 0);
    chk("squash_no_write", wen_BHT, 0);
    chk("squash_mcount", mispredict_count, 1);
    step();

    // Not-taken mispredict
    set_in(1, 1, 0, 0, 0, 16'h0099, 16'h0010, 2'b11, 16'h0000); #1;
    chk("nt_wen_BTB", wen_BTB, 0);
    chk("nt_wen_BHT", wen_BHT, 1);
    chk("nt_redirect", redirect_target, 16'h0012);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    // Target miss, then a fully correct prediction
    set_in(1, 1, 0, 0, 1, 16'h0024, 16'h0030, 2'b10, 16'h0020); #1;
    chk("tmiss_update_PC", update_PC, 1);
    chk("tmiss_wen_BTB", wen_BTB, 1);
    chk("tmiss_target", upd_target, 16'h0024);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    set_in(1, 1, 0, 0, 1, 16'h0050, 16'h0032, 2'b10, 16'h0050); #1;
    chk("ok_update_PC", update_PC, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("ok_bcount", branch_count, 4);
    chk("ok_mcount", mispredict_count, 3);
    step();

    // Stalled branch writes once, on release
    set_in(1, 1, 0, 1, 0, 16'h0000, 16'h0040, 2'b00, 16'h0000);
    repeat (3) begin
      #1; chk("stall_no_write", wen_BHT, 0);
      step();
    end
    hazard_stall = 0; #1;
    chk("stall_release_write", wen_BHT, 1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("stall_bcount", branch_count, 5);
    step();

    // HLT beats a branch, then stays halted
    set_in(1, 1, 1, 0, 1, 16'h0010, 16'h0044, 2'b00, 16'h0000); #1;
    chk("hlt_no_write", wen_BHT, 0);
    step();
    repeat (10) begin
      set_in($urandom_range(0, 1), $urandom_range(0, 1), 0, $urandom_range(0, 1),
             $urandom_range(0, 1), 16'($urandom), 16'($urandom), 2'($urandom), 16'($urandom));
      #1;
      chk("halt_halted", halted, 1);
      chk("halt_pc_en", pc_en, 0);
      step();
    end

    // Reset mid-HALT, then mid-INIT at idx 7
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (7) step();
    #1; chk("mid_init_idx7", upd_idx, 7);
    do_reset();

    // Randomized traffic
    halt_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      bit tk;
      logic [15:0] tgt;
      tk  = $urandom_range(0, 1);
      tgt = 16'($urandom) & 16'hFFFE;
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 249) == 0,
             $urandom_range(0, 3) == 0, tk, tgt, 16'($urandom) & 16'hFFFE, 2'($urandom),
             ($urandom_range(0, 1) != 0) ? tgt : 16'($urandom));
      step();
      halt_cycles = m_halt ? halt_cycles + 1 : 0;
      if (halt_cycles > 5 || $urandom_range(0, 399) == 0) begin
        do_reset();
        halt_cycles = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
